// File: rtl/stg4ma_dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stg4ma_dmem_resp_pkg
// Description : Shared widths, FSM state type and range helper for the
//               memory-access stage data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package stg4ma_dmem_resp_pkg;

    localparam int c_size_addr = 16;
    localparam int c_size_data = 16;
    localparam int c_cnt_w     = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // True when any address bit above the array index range is set.
    function automatic logic addr_out_of_range(input logic [c_size_addr-1:0] addr,
                                               input int depth_log2);
        return (addr >> depth_log2) != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stg4ma_dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : stg4ma_dmem_array
// Description : Single-port synchronous word RAM, read-first, registered
//               read data updated only when enabled. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stg4ma_dmem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WIDTH      = 16
) (
    input  logic                  iw_clk,
    input  logic                  iw_en,
    input  logic                  iw_we,
    input  logic [DEPTH_LOG2-1:0] iw_addr,
    input  logic [WIDTH-1:0]      iw_wdata,
    output logic [WIDTH-1:0]      ow_rdata
);

    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge iw_clk) begin
        if (iw_en) begin
            if (iw_we) begin
                r_mem[iw_addr] <= iw_wdata;
            end
            r_rdata <= r_mem[iw_addr];
        end
    end

    assign ow_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/stg4ma_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module      : stg4ma_dmem_resp
// Description : Fixed-latency data-memory responder for the MA stage; one
//               outstanding request, valid/ready request and response ports.
// Revision    : 1.0 - initial release
// ============================================================================
module stg4ma_dmem_resp
    import stg4ma_dmem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                   iw_clk,
    input  logic                   iw_rst,
    input  logic                   iw_req_valid,
    output logic                   ow_req_ready,
    input  logic                   iw_req_we,
    input  logic [c_size_addr-1:0] iw_req_addr,
    input  logic [c_size_data-1:0] iw_req_wdata,
    input  logic [c_size_addr-1:0] iw_req_pc,
    output logic                   ow_rsp_valid,
    input  logic                   iw_rsp_ready,
    output logic [c_size_data-1:0] ow_rsp_rdata,
    output logic                   ow_rsp_we,
    output logic                   ow_rsp_err,
    output logic [c_size_addr-1:0] ow_rsp_pc
);

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_we;
    logic [c_size_addr-1:0] r_addr;
    logic [c_size_data-1:0] r_wdata;
    logic [c_size_addr-1:0] r_pc;
    logic                   r_rsp_valid;
    logic                   r_rsp_we;
    logic                   r_rsp_err;
    logic [c_size_addr-1:0] r_rsp_pc;
    logic                   r_rdata_sel;

    logic                   w_access;
    logic                   w_err;
    logic [c_size_data-1:0] w_ram_rdata;

    assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_err    = addr_out_of_range(r_addr, DEPTH_LOG2);

    // Write is gated by reset so a transaction dropped in S_WAIT never commits.
    stg4ma_dmem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (c_size_data)
    ) u_array (
        .iw_clk   (iw_clk),
        .iw_en    (w_access && !w_err && !iw_rst),
        .iw_we    (w_access && !w_err && r_we && !iw_rst),
        .iw_addr  (r_addr[DEPTH_LOG2-1:0]),
        .iw_wdata (r_wdata),
        .ow_rdata (w_ram_rdata)
    );

    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pc        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_pc    <= '0;
            r_rdata_sel <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iw_req_valid) begin
                        r_we    <= iw_req_we;
                        r_addr  <= iw_req_addr;
                        r_wdata <= iw_req_wdata;
                        r_pc    <= iw_req_pc;
                        r_cnt   <= c_cnt_w'(LATENCY - 1);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_we    <= r_we;
                        r_rsp_pc    <= r_pc;
                        r_rsp_err   <= w_err;
                        r_rdata_sel <= !r_we && !w_err;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (iw_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ow_req_ready = (r_state == S_IDLE);
    assign ow_rsp_valid = r_rsp_valid;
    assign ow_rsp_we    = r_rsp_we;
    assign ow_rsp_err   = r_rsp_err;
    assign ow_rsp_pc    = r_rsp_pc;
    // RAM output register holds between accesses, so masking keeps rdata stable.
    assign ow_rsp_rdata = r_rdata_sel ? w_ram_rdata : '0;

endmodule
`default_nettype wire

// File: doc/stg4ma_dmem_resp.md
Name: stg4ma_dmem_resp

Overview:
- Data-memory responder serving the memory-access stage. It is the far end of that stage's load/store request interface.
- Accepts one request at a time (address, write flag, write data, pc tag). After a fixed, parameterised wait it performs the access on an internal word array.
- Returns read data or a write acknowledge through a valid/ready response channel.
- Sits beside the MA pipeline stage and replaces an ideal zero-latency memory in the core.

Parameters:
- DEPTH_LOG2, 8, array holds 2**DEPTH_LOG2 words of `SIZE_DATA bits.
- LATENCY, 2, clocks from the accepting edge to the response-valid edge. Legal range 1..15.

Ports:
- iw_clk  in  1  clock, rising edge.
- iw_rst  in  1  reset; synchronous, active-high.
- iw_req_valid  in  1  request present.
- ow_req_ready  out  1  responder can accept.
- iw_req_we  in  1  1=store, 0=load.
- iw_req_addr  in  `SIZE_ADDR  word address.
- iw_req_wdata  in  `SIZE_DATA  store data.
- iw_req_pc  in  `SIZE_ADDR  tag, echoed in response.
- ow_rsp_valid  out  1  response present.
- iw_rsp_ready  in  1  consumer accepts response.
- ow_rsp_rdata  out  `SIZE_DATA  load data; 0 for stores and errors.
- ow_rsp_we  out  1  echo of request type.
- ow_rsp_err  out  1  address out of range.
- ow_rsp_pc  out  `SIZE_ADDR  echoed tag.

Behaviour:
- FSM states: S_IDLE, S_WAIT, S_RESP. The state encoding is a 2-bit register.
- Reset (sampled on rising edge while iw_rst=1):
  - state=S_IDLE, wait counter=0.
  - ow_rsp_valid=0, ow_rsp_rdata=0, ow_rsp_we=0, ow_rsp_err=0, ow_rsp_pc=0.
  - Captured request registers cleared to 0.
  - Array contents are NOT cleared.
- ow_req_ready = (state==S_IDLE). It is decoded from state only and must never depend on iw_req_valid.
- S_IDLE: on edge with iw_req_valid & ow_req_ready:
  - Capture we/addr/wdata/pc.
  - Load counter with LATENCY-1.
  - Go to S_WAIT.
- S_WAIT, counter != 0: decrement.
- S_WAIT, counter == 0: perform the access at this edge, then go to S_RESP.
  - Range check: range error when captured addr >= 2**DEPTH_LOG2, i.e. any bit above DEPTH_LOG2-1 is set.
  - Store without error: array[addr] <= wdata; rdata <= 0.
  - Load without error: rdata <= array[addr], i.e. the pre-edge contents.
  - Error: no array write; rdata <= 0; err <= 1.
  - we and pc are copied to the response outputs.
- S_RESP: ow_rsp_valid=1.
  - All rsp outputs are held stable until iw_rsp_ready=1.
  - On the handshake edge: ow_rsp_valid<=0, go to S_IDLE.
  - A new request can be accepted one cycle later, in S_IDLE.
- Timing: ow_rsp_valid rises exactly LATENCY edges after the accepting edge. With zero backpressure the throughput is 1 request per LATENCY+2 cycles.
- Only one transaction is outstanding at a time, so there are no read-after-write hazards inside the block.
- iw_req_valid while not ready is ignored. The requester holds the request; nothing is captured.
- iw_rsp_ready while ow_rsp_valid=0 has no effect.
- Reset mid-operation:
  - In S_WAIT: the transaction is dropped and no write occurs.
  - In S_RESP: the write has already committed; the response is discarded.
- Address/data widths follow `SIZE_ADDR / `SIZE_DATA from the shared sizes header. DEPTH_LOG2 must be <= `SIZE_ADDR.

Decomposition:
- Shared header (sizes.vh): existing `SIZE_ADDR/`SIZE_DATA/`HBIT_*. Add the state localparams S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2 only if another block reuses them; otherwise they stay local.
- One natural sub-module: stg4ma_dmem_array, a single-port synchronous word RAM (write enable, address, wdata, registered rdata), so it can be swapped for a vendor BRAM.
- FSM, counter, range check and response registers stay in the top module.

Test Plan:
- Reset then idle: iw_rst=1 for 2 clocks -> ow_req_ready=1, ow_rsp_valid=0, all rsp outputs 0.
- Store then load:
  - store addr=0x05, wdata=0xA5A5, pc=0x10 -> rsp_valid at accept+2, rsp_we=1, rdata=0, pc=0x10.
  - load addr=0x05, pc=0x14 -> rdata=0xA5A5, err=0, pc=0x14.
- Backpressure: load held in S_RESP with iw_rsp_ready=0 for 5 clocks -> outputs stable for those 5 clocks; ow_req_ready=0 throughout. A new iw_req_valid during that window is not captured.
- Out of range (DEPTH_LOG2=8): store addr=0x100, wdata=0xFFFF -> err=1, rdata=0; a following load addr=0x00 returns the previous contents unchanged.
- LATENCY=1 and LATENCY=15 builds: measure the accept-to-valid edge count -> exactly 1 and 15; back-to-back stream of 4 loads completes in order with correct tags.
- Reset mid-op: assert iw_rst during S_WAIT of a store to addr=0x07 with wdata=0x1234 -> after reset, a load of 0x07 returns the old value, and no response for the dropped store ever appears.
